// File: rtl/xcvr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xcvr_pkg
//  Description : Shared types, default timing constants and constant helper
//                functions for the TX transceiver reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package xcvr_pkg;

    // Sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        S_ANALOG_ASSERT   = 3'd0,
        S_WAIT_LOCK       = 3'd1,
        S_ANALOG_RELEASE  = 3'd2,
        S_DIGITAL_WAIT    = 3'd3,
        S_DIGITAL_RELEASE = 3'd4,
        S_READY           = 3'd5,
        S_RELOCK          = 3'd6
    } state_t;

    // Default timing (in clock cycles).
    localparam int c_DEF_LANES        = 4;
    localparam int c_DEF_T_ANALOG     = 70;
    localparam int c_DEF_T_DIGITAL    = 20;
    localparam int c_DEF_LOCK_FILTER  = 16;
    localparam int c_DEF_STAT_TIMEOUT = 1024;

    // Ceiling log2, never below 1 so that it can size a vector directly.
    function automatic int xcvr_clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int xcvr_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : xcvr_pkg
`default_nettype wire

// File: rtl/xcvr_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : xcvr_sync_filter
//  Description : WIDTH-bit 2-flop synchronizer with an optional saturating
//                debounce counter. With FILTER > 0, filt_ok asserts once all
//                synchronized bits have been high for FILTER consecutive
//                cycles; any low cycle restarts the count. With FILTER = 0,
//                filt_ok is simply the AND of the synchronized bits.
//  Ports       : clock, reset   - clock / synchronous active-high reset
//                din            - asynchronous input bus
//                dout           - synchronized bus (2 cycles latency)
//                filt_ok        - debounced "all high" indication
//  Revision    : 1.0 - initial release
// ============================================================================
module xcvr_sync_filter #(
    parameter int WIDTH  = 1,
    parameter int FILTER = 0,
    parameter int CNT_W  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             filt_ok
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
        end
    end

    assign dout = r_sync;

    generate
        if (FILTER > 0) begin : g_filter
            logic [CNT_W-1:0] r_cnt;

            // Saturating run-length counter of consecutive all-high cycles.
            always_ff @(posedge clock) begin
                if (reset || !(&r_sync)) begin
                    r_cnt <= '0;
                end else if (r_cnt != CNT_W'(FILTER)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign filt_ok = (r_cnt == CNT_W'(FILTER));
        end else begin : g_no_filter
            assign filt_ok = &r_sync;
        end
    endgenerate

endmodule : xcvr_sync_filter
`default_nettype wire

// File: rtl/xcvr_tx_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : xcvr_tx_reset_sequencer
//  Description : Soft reset sequencer for LANES bonded TX transceiver lanes
//                sharing one TX PLL. Orders analog/digital resets against PLL
//                lock, calibration busy and per-lane reset-status acks, with
//                lane masking, loss-of-lock recovery and ack timeout.
//  Ports       : clock, reset           - clock / sync active-high reset
//                pll_locked             - TX PLL lock (async)
//                tx_cal_busy[L]         - per-lane calibration busy (async)
//                lane_enable[L]         - lane participation mask
//                tx_analogreset[L]      - analog reset to transceiver
//                tx_digitalreset[L]     - digital reset to transceiver
//                tx_analogreset_stat[L] - analog reset ack (async)
//                tx_digitalreset_stat[L]- digital reset ack (async)
//                tx_ready[L]            - lane usable
//                tx_reset               - datapath reset, low when all
//                                         enabled lanes are ready
//                error                  - sticky ack timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module xcvr_tx_reset_sequencer
    import xcvr_pkg::*;
#(
    parameter int LANES        = c_DEF_LANES,
    parameter int T_ANALOG     = c_DEF_T_ANALOG,
    parameter int T_DIGITAL    = c_DEF_T_DIGITAL,
    parameter int LOCK_FILTER  = c_DEF_LOCK_FILTER,
    parameter int STAT_TIMEOUT = c_DEF_STAT_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic [LANES-1:0] tx_cal_busy,
    input  logic [LANES-1:0] lane_enable,
    output logic [LANES-1:0] tx_analogreset,
    output logic [LANES-1:0] tx_digitalreset,
    input  logic [LANES-1:0] tx_analogreset_stat,
    input  logic [LANES-1:0] tx_digitalreset_stat,
    output logic [LANES-1:0] tx_ready,
    output logic             tx_reset,
    output logic             error
);

    localparam int c_CNT_MAX_I = xcvr_max(xcvr_max(T_ANALOG, T_DIGITAL),
                                          xcvr_max(LOCK_FILTER, STAT_TIMEOUT));
    localparam int c_CNT_W     = xcvr_clog2(c_CNT_MAX_I + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(c_CNT_MAX_I);
    localparam logic [c_CNT_W-1:0] c_T_ANALOG   = c_CNT_W'(T_ANALOG);
    // Last count value of a phase: the phase lasts (value + 1) cycles.
    localparam logic [c_CNT_W-1:0] c_T_DIG_LAST = c_CNT_W'((T_DIGITAL > 0) ? T_DIGITAL - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST   = c_CNT_W'((STAT_TIMEOUT > 0) ? STAT_TIMEOUT - 1 : 0);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic             w_lock_s;
    logic             w_lock_ok;
    logic [LANES-1:0] w_cal_s;
    logic [LANES-1:0] w_astat_s;
    logic [LANES-1:0] w_dstat_s;
    logic             w_cal_ok_unused;
    logic             w_astat_ok_unused;
    logic             w_dstat_ok_unused;

    xcvr_sync_filter #(.WIDTH(1), .FILTER(LOCK_FILTER), .CNT_W(c_CNT_W)) u_sync_lock (
        .clock   (clock),
        .reset   (reset),
        .din     (pll_locked),
        .dout    (w_lock_s),
        .filt_ok (w_lock_ok)
    );

    xcvr_sync_filter #(.WIDTH(LANES), .FILTER(0), .CNT_W(c_CNT_W)) u_sync_cal (
        .clock   (clock),
        .reset   (reset),
        .din     (tx_cal_busy),
        .dout    (w_cal_s),
        .filt_ok (w_cal_ok_unused)
    );

    xcvr_sync_filter #(.WIDTH(LANES), .FILTER(0), .CNT_W(c_CNT_W)) u_sync_astat (
        .clock   (clock),
        .reset   (reset),
        .din     (tx_analogreset_stat),
        .dout    (w_astat_s),
        .filt_ok (w_astat_ok_unused)
    );

    xcvr_sync_filter #(.WIDTH(LANES), .FILTER(0), .CNT_W(c_CNT_W)) u_sync_dstat (
        .clock   (clock),
        .reset   (reset),
        .din     (tx_digitalreset_stat),
        .dout    (w_dstat_s),
        .filt_ok (w_dstat_ok_unused)
    );

    logic w_unused;
    assign w_unused = w_cal_ok_unused & w_astat_ok_unused & w_dstat_ok_unused;

    // ------------------------------------------------------------------
    // Lane-masked conditions: disabled lanes never block or trigger.
    // ------------------------------------------------------------------
    logic [LANES-1:0] r_en_prev;
    logic             r_cal_any;
    logic             w_en_any;
    logic             w_en_change;
    logic             w_cal_any;
    logic             w_cal_rise;
    logic             w_astat_hi;
    logic             w_astat_lo;
    logic             w_dstat_lo;

    assign w_en_any    = |lane_enable;
    assign w_en_change = (lane_enable != r_en_prev);
    assign w_cal_any   = |(w_cal_s & lane_enable);
    assign w_cal_rise  = w_cal_any & ~r_cal_any;
    assign w_astat_hi  = &(w_astat_s | ~lane_enable);
    assign w_astat_lo  = ~|(w_astat_s & lane_enable);
    assign w_dstat_lo  = ~|(w_dstat_s & lane_enable);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;      // phase timer, cleared on every state change
    logic [c_CNT_W-1:0]   r_tmo;      // ack-wait timer, runs only while an ack is awaited
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_CNT_W-1:0]   w_tmo_next;
    logic                 w_tmo_run;
    logic                 w_timeout;
    logic                 w_relock;
    logic                 w_err_set;
    logic [LANES-1:0]     w_ana_next;
    logic [LANES-1:0]     w_dig_next;
    logic [LANES-1:0]     w_rdy_next;
    logic                 w_txrst_next;

    logic                 r_error;
    logic [LANES-1:0]     r_ana;
    logic [LANES-1:0]     r_dig;
    logic [LANES-1:0]     r_rdy;
    logic                 r_txrst;

    always_comb begin
        w_state_next = r_state;
        w_tmo_run    = 1'b0;
        w_timeout    = 1'b0;
        w_relock     = 1'b0;

        case (r_state)
            S_ANALOG_ASSERT: begin
                // The ack wait only starts once the minimum hold has elapsed.
                w_tmo_run = (r_cnt >= c_T_ANALOG);
                if (w_en_any && w_tmo_run && w_astat_hi) begin
                    w_state_next = S_WAIT_LOCK;
                end else if (w_tmo_run && !w_astat_hi && (r_tmo >= c_TMO_LAST)) begin
                    w_timeout = 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (!w_cal_any && w_lock_ok) begin
                    w_state_next = S_ANALOG_RELEASE;
                end
            end
            S_ANALOG_RELEASE: begin
                w_tmo_run = 1'b1;
                if (w_astat_lo) begin
                    w_state_next = S_DIGITAL_WAIT;
                end else if (r_tmo >= c_TMO_LAST) begin
                    w_timeout = 1'b1;
                end
            end
            S_DIGITAL_WAIT: begin
                if (r_cnt >= c_T_DIG_LAST) begin
                    w_state_next = S_DIGITAL_RELEASE;
                end
            end
            S_DIGITAL_RELEASE: begin
                w_tmo_run = 1'b1;
                if (w_dstat_lo) begin
                    w_state_next = S_READY;
                end else if (r_tmo >= c_TMO_LAST) begin
                    w_timeout = 1'b1;
                end
            end
            S_READY: begin
                if (w_cal_rise) begin
                    w_state_next = S_ANALOG_ASSERT;
                end
            end
            S_RELOCK: begin
                if (!w_cal_any && w_lock_ok) begin
                    w_state_next = S_DIGITAL_WAIT;
                end
            end
            default: begin
                w_state_next = S_ANALOG_ASSERT;
            end
        endcase

        // Overrides applied lowest priority first so later ones win.
        if (w_timeout) begin
            w_state_next = S_ANALOG_ASSERT;
        end
        if (!w_lock_s && ((r_state == S_READY) || (r_state == S_DIGITAL_WAIT) ||
                          (r_state == S_DIGITAL_RELEASE))) begin
            w_relock     = 1'b1;
            w_state_next = S_RELOCK;
        end
        if (w_en_change) begin
            w_state_next = S_ANALOG_ASSERT;
        end
        w_err_set = w_timeout && !w_relock && !w_en_change;

        // Counters: cleared on any state change or mask change, saturating otherwise.
        if ((w_state_next != r_state) || w_en_change) begin
            w_cnt_next = '0;
            w_tmo_next = '0;
        end else begin
            w_cnt_next = (r_cnt != c_CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
            w_tmo_next = (w_tmo_run && (r_tmo != c_CNT_MAX)) ? r_tmo + 1'b1 : r_tmo;
        end

        // Outputs are registered from the next state so they change with it.
        w_ana_next = '1;
        w_dig_next = '1;
        w_rdy_next = '0;
        case (w_state_next)
            S_ANALOG_RELEASE, S_DIGITAL_WAIT, S_RELOCK: begin
                w_ana_next = ~lane_enable;
            end
            S_DIGITAL_RELEASE: begin
                w_ana_next = ~lane_enable;
                w_dig_next = ~lane_enable;
            end
            S_READY: begin
                w_ana_next = ~lane_enable;
                w_dig_next = ~lane_enable;
                w_rdy_next = lane_enable;
            end
            default: begin
                w_ana_next = '1;
            end
        endcase
        // Datapath reset drops one cycle after READY is entered.
        w_txrst_next = !((r_state == S_READY) && (w_state_next == S_READY));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_ANALOG_ASSERT;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_en_prev <= lane_enable;
            r_cal_any <= 1'b0;
            r_error   <= 1'b0;
            r_ana     <= '1;
            r_dig     <= '1;
            r_rdy     <= '0;
            r_txrst   <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_tmo     <= w_tmo_next;
            r_en_prev <= lane_enable;
            r_cal_any <= w_cal_any;
            r_error   <= r_error | w_err_set;
            r_ana     <= w_ana_next;
            r_dig     <= w_dig_next;
            r_rdy     <= w_rdy_next;
            r_txrst   <= w_txrst_next;
        end
    end

    assign tx_analogreset  = r_ana;
    assign tx_digitalreset = r_dig;
    assign tx_ready        = r_rdy;
    assign tx_reset        = r_txrst;
    assign error           = r_error;

endmodule : xcvr_tx_reset_sequencer
`default_nettype wire

// File: tb/tb_xcvr_tx_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xcvr_tx_reset_sequencer
//  Description : Directed self-checking bench for xcvr_tx_reset_sequencer
//                (LANES=4, default timing). A simple transceiver model echoes
//                each reset request on its status output 3 cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xcvr_tx_reset_sequencer;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       pll_locked  = 1'b1;
    logic [3:0] tx_cal_busy = 4'h0;
    logic [3:0] lane_enable = 4'hF;
    logic [3:0] tx_analogreset;
    logic [3:0] tx_digitalreset;
    logic [3:0] tx_analogreset_stat;
    logic [3:0] tx_digitalreset_stat;
    logic [3:0] tx_ready;
    logic       tx_reset;
    logic       error;

    always #5 clock = ~clock;

    xcvr_tx_reset_sequencer u_dut (
        .clock                (clock),
        .reset                (reset),
        .pll_locked           (pll_locked),
        .tx_cal_busy          (tx_cal_busy),
        .lane_enable          (lane_enable),
        .tx_analogreset       (tx_analogreset),
        .tx_digitalreset      (tx_digitalreset),
        .tx_analogreset_stat  (tx_analogreset_stat),
        .tx_digitalreset_stat (tx_digitalreset_stat),
        .tx_ready             (tx_ready),
        .tx_reset             (tx_reset),
        .error                (error)
    );

    // Transceiver model: status follows the request with 3 cycles of delay.
    logic [3:0] r_ana_d1 = 4'hF, r_ana_d2 = 4'hF, r_ana_d3 = 4'hF;
    logic [3:0] r_dig_d1 = 4'hF, r_dig_d2 = 4'hF, r_dig_d3 = 4'hF;
    logic [3:0] r_junk   = 4'h5;
    logic [3:0] junk_mask  = 4'h0;   // lanes whose stats carry garbage
    logic [3:0] stuck_mask = 4'h0;   // lanes whose digital stat is stuck high

    always_ff @(posedge clock) begin
        r_ana_d1 <= tx_analogreset;
        r_ana_d2 <= r_ana_d1;
        r_ana_d3 <= r_ana_d2;
        r_dig_d1 <= tx_digitalreset;
        r_dig_d2 <= r_dig_d1;
        r_dig_d3 <= r_dig_d2;
        r_junk   <= ~r_junk;
    end

    assign tx_analogreset_stat  = (r_ana_d3 & ~junk_mask) | (r_junk & junk_mask);
    assign tx_digitalreset_stat = (r_dig_d3 & ~junk_mask) | (r_junk & junk_mask) | stuck_mask;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs from reset release until tx_reset drops; records first cycle the
    // analog reset falls, enabled analog stats all read low, digital reset
    // falls. Values stay -1 if not observed within the budget.
    task automatic bring_up(input int budget, output int t_ana, output int t_stat,
                            output int t_dig, output int t_done);
        t_ana  = -1;
        t_stat = -1;
        t_dig  = -1;
        t_done = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (t_ana < 0 && tx_analogreset != 4'hF) t_ana = c;
            if (t_ana >= 0 && t_stat < 0 && (tx_analogreset_stat & lane_enable) == 4'h0) t_stat = c;
            if (t_dig < 0 && tx_digitalreset != 4'hF) t_dig = c;
            if (tx_reset == 1'b0) begin
                t_done = c;
                break;
            end
        end
    endtask

    int t_ana, t_stat, t_dig, t_done, k;
    logic ana_low;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_analog",  tx_analogreset,  4'hF);
        check("rst_digital", tx_digitalreset, 4'hF);
        check("rst_ready",   tx_ready,        4'h0);
        check("rst_txreset", tx_reset,        1'b1);
        check("rst_error",   error,           1'b0);

        // ---------------- nominal bring-up ----------------
        reset = 1'b0;
        bring_up(2000, t_ana, t_stat, t_dig, t_done);
        check("nom_done",        t_done > 0, 1);
        check("nom_ana_ge_70",   t_ana >= 70, 1);
        check("nom_ana_le_80",   t_ana <= 80, 1);
        check("nom_dig_gap_20",  (t_dig - t_stat) >= 20, 1);
        check("nom_ready",       tx_ready,        4'hF);
        check("nom_analog",      tx_analogreset,  4'h0);
        check("nom_digital",     tx_digitalreset, 4'h0);
        check("nom_error",       error,           1'b0);

        // ---------------- lock loss ----------------
        repeat (5) tick();
        pll_locked = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) begin
                check("lol_digital", tx_digitalreset, 4'hF);
                check("lol_txreset", tx_reset,        1'b1);
                check("lol_analog",  tx_analogreset,  4'h0);
            end
        end
        pll_locked = 1'b1;
        ana_low = 1'b1;
        k = -1;
        for (int c = 1; c <= 500; c++) begin
            tick();
            if (tx_analogreset != 4'h0) ana_low = 1'b0;
            if (tx_ready == 4'hF && tx_reset == 1'b0) begin
                k = c;
                break;
            end
        end
        check("lol_recovered",    k > 0, 1);
        check("lol_ready_ge_36",  k >= 36, 1);
        check("lol_analog_held",  ana_low, 1'b1);

        // ---------------- cal_busy hold ----------------
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tx_cal_busy = 4'b0100;
        fork
            begin
                repeat (300) tick();
                tx_cal_busy = 4'h0;
            end
        join_none
        bring_up(1000, t_ana, t_stat, t_dig, t_done);
        check("cal_ana_ge_303", t_ana >= 303, 1);
        check("cal_ana_le_305", t_ana <= 305, 1);
        check("cal_done",       t_done > 0, 1);
        check("cal_ready",      tx_ready, 4'hF);

        // ---------------- stat timeout ----------------
        reset = 1'b1;
        stuck_mask = 4'b0010;
        repeat (2) tick();
        reset = 1'b0;
        k = -1;
        for (int c = 1; c <= 500; c++) begin
            tick();
            if (tx_digitalreset == 4'h0) begin
                k = c;
                break;
            end
        end
        check("tmo_dr_entered", k > 0, 1);
        k = -1;
        for (int c = 1; c <= 1100; c++) begin
            tick();
            if (error == 1'b1) begin
                k = c;
                break;
            end
        end
        check("tmo_cycles",     k, 1024);
        check("tmo_analog_re",  tx_analogreset,  4'hF);
        check("tmo_digital_re", tx_digitalreset, 4'hF);
        check("tmo_txreset",    tx_reset,        1'b1);
        repeat (200) tick();
        check("tmo_error_sticky", error,          1'b1);
        check("tmo_resequence",   tx_analogreset, 4'h0);

        // ---------------- lane mask ----------------
        reset = 1'b1;
        stuck_mask  = 4'h0;
        lane_enable = 4'b0101;
        junk_mask   = 4'b1010;
        repeat (2) tick();
        check("mask_error_cleared", error, 1'b0);
        reset = 1'b0;
        bring_up(2000, t_ana, t_stat, t_dig, t_done);
        check("mask_done",    t_done > 0, 1);
        check("mask_ready",   tx_ready,        4'b0101);
        check("mask_analog",  tx_analogreset,  4'b1010);
        check("mask_digital", tx_digitalreset, 4'b1010);
        check("mask_txreset", tx_reset,        1'b0);
        lane_enable = 4'b1101;
        junk_mask   = 4'b0010;
        tick();
        check("mask_chg_ready",   tx_ready,       4'h0);
        check("mask_chg_txreset", tx_reset,       1'b1);
        check("mask_chg_analog",  tx_analogreset, 4'hF);
        check("mask_chg_error",   error,          1'b0);

        // ---------------- reset mid-operation ----------------
        reset = 1'b1;
        lane_enable = 4'hF;
        junk_mask   = 4'h0;
        repeat (2) tick();
        reset = 1'b0;
        k = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (tx_analogreset == 4'h0) begin
                k = c;
                break;
            end
        end
        check("mid_analog_fell", k > 0, 1);
        repeat (10) tick();
        check("mid_in_dwait_dig", tx_digitalreset, 4'hF);
        check("mid_in_dwait_ana", tx_analogreset,  4'h0);
        reset = 1'b1;
        tick();
        check("mid_rst_analog",  tx_analogreset,  4'hF);
        check("mid_rst_digital", tx_digitalreset, 4'hF);
        check("mid_rst_ready",   tx_ready,        4'h0);
        check("mid_rst_txreset", tx_reset,        1'b1);
        check("mid_rst_error",   error,           1'b0);
        reset = 1'b0;
        bring_up(2000, t_ana, t_stat, t_dig, t_done);
        check("mid_restart_done",  t_done > 0, 1);
        check("mid_restart_ana70", t_ana >= 70, 1);
        check("mid_restart_ready", tx_ready, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_xcvr_tx_reset_sequencer
`default_nettype wire
